// File: rtl/trap_sequencer.sv
`default_nettype none
// ==== trap_sequencer : M-mode ecall/mret sequencer sharing one CSR write port ====
// ==== rev 1.0                                                                 ====
module trap_sequencer #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] ECALL_CAUSE = 'hb
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ecall_req_i,
  input  logic            mret_req_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            inst_csr_we_i,
  input  logic [11:0]     inst_csr_addr_i,
  input  logic [XLEN-1:0] inst_csr_wdata_i,
  input  logic [XLEN-1:0] csr_mtvec_i,
  input  logic [XLEN-1:0] csr_mepc_i,
  input  logic [XLEN-1:0] csr_mstatus_i,
  output logic            csr_we_o,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic            redirect_ready_i,
  output logic            busy_o
);

  typedef enum logic [2:0] {
    S_IDLE           = 3'd0,
    S_SAVE_EPC       = 3'd1,
    S_SAVE_CAUSE     = 3'd2,
    S_SAVE_STATUS    = 3'd3,
    S_RESTORE_STATUS = 3'd4,
    S_REDIRECT       = 3'd5
  } state_e;

  localparam logic [11:0]     C_MSTATUS    = 12'h300;
  localparam logic [11:0]     C_MEPC       = 12'h341;
  localparam logic [11:0]     C_MCAUSE     = 12'h342;
  localparam logic [XLEN-1:0] C_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  state_e          state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] status_q, status_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] w_entry_status;
  logic [XLEN-1:0] w_return_status;

  // Machine-mode only, so MPP is always forced to M on both entry and return.
  always_comb begin
    w_entry_status         = status_q;
    w_entry_status[7]      = status_q[3];
    w_entry_status[3]      = 1'b0;
    w_entry_status[12:11]  = 2'b11;
    w_return_status        = status_q;
    w_return_status[3]     = status_q[7];
    w_return_status[7]     = 1'b1;
    w_return_status[12:11] = 2'b11;
  end

  always_comb begin
    state_d          = state_q;
    epc_d            = epc_q;
    status_d         = status_q;
    target_d         = target_q;
    csr_we_o         = 1'b0;
    csr_waddr_o      = 12'h000;
    csr_wdata_o      = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    busy_o           = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy_o      = 1'b0;
        csr_we_o    = inst_csr_we_i;
        csr_waddr_o = inst_csr_addr_i;
        csr_wdata_o = inst_csr_wdata_i;
        if (ecall_req_i) begin
          epc_d   = trap_pc_i;
          state_d = S_SAVE_EPC;
        end else if (mret_req_i) begin
          status_d = csr_mstatus_i;
          target_d = csr_mepc_i & C_ALIGN_MASK;
          state_d  = S_RESTORE_STATUS;
        end
      end
      S_SAVE_EPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = C_MEPC;
        csr_wdata_o = epc_q;
        state_d     = S_SAVE_CAUSE;
      end
      S_SAVE_CAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = C_MCAUSE;
        csr_wdata_o = ECALL_CAUSE;
        status_d    = csr_mstatus_i;
        target_d    = csr_mtvec_i & C_ALIGN_MASK;
        state_d     = S_SAVE_STATUS;
      end
      S_SAVE_STATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = C_MSTATUS;
        csr_wdata_o = w_entry_status;
        state_d     = S_REDIRECT;
      end
      S_RESTORE_STATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = C_MSTATUS;
        csr_wdata_o = w_return_status;
        state_d     = S_REDIRECT;
      end
      S_REDIRECT: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = target_q;
        if (redirect_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      epc_q    <= '0;
      status_q <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      epc_q    <= epc_d;
      status_q <= status_d;
      target_q <= target_d;
    end
  end

endmodule
`default_nettype wire
